// File: rtl/cu_pkg.sv
// Shared types and constants for the calculator control unit.
// State encoding, ctrl field layout and per-state ctrl words.
package cu_pkg;

  typedef enum logic [4:0] {
    IDLE = 5'd0,
    S1   = 5'd1,
    S2   = 5'd2,
    DISP = 5'd3,
    S3_0 = 5'd4,
    S3_1 = 5'd5,
    S3_2 = 5'd6,
    S3_3 = 5'd7,
    S6_0 = 5'd8,
    S6_1 = 5'd9,
    S6_2 = 5'd10,
    S6_3 = 5'd11,
    S4_0 = 5'd12,
    S4_1 = 5'd13,
    S5   = 5'd14,
    S7   = 5'd15,
    S8   = 5'd16,
    S9_0 = 5'd17,
    S9_1 = 5'd18,
    S9_2 = 5'd19
  } state_t;

  localparam int CTRL_W  = 14;
  localparam int LD_IN   = 13;
  localparam int LD_A    = 12;
  localparam int LD_B    = 11;
  localparam int CALC_EN = 10;
  localparam int ALU_OP  = 8;
  localparam int DIV_EN  = 7;
  localparam int MUL_EN  = 6;
  localparam int RES_SEL = 4;
  localparam int ACC_EN  = 3;
  localparam int RES_EN  = 2;
  localparam int OUT_SEL = 0;

  localparam logic [13:0] C_ZERO = 14'h0000;
  localparam logic [13:0] C_S1   = 14'h3800;
  localparam logic [13:0] C_S2   = 14'h2000;
  localparam logic [13:0] C_S3   = 14'h0400;
  localparam logic [13:0] C_S6   = 14'h0414;
  localparam logic [13:0] C_S4_0 = 14'h0060;
  localparam logic [13:0] C_S4_1 = 14'h006C;
  localparam logic [13:0] C_S8   = 14'h006C;
  localparam logic [13:0] C_S5   = 14'h0080;
  localparam logic [13:0] C_S7   = 14'h00BC;
  localparam logic [13:0] C_S9_0 = 14'h0001;
  localparam logic [13:0] C_S9_1 = 14'h0002;
  localparam logic [13:0] C_S9_2 = 14'h0003;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_MUL  = 3'b101;
  localparam logic [2:0] F_OUT1 = 3'b110;
  localparam logic [2:0] F_OUT2 = 3'b111;

  function automatic logic [13:0] alu_word(
    input logic [13:0] base,
    input logic [1:0]  op
  );
    logic [13:0] w;
    w = base;
    w[ALU_OP +: 2] = op;
    return w;
  endfunction

endpackage

// File: rtl/cu.sv
// Moore control unit for the calculator datapath.
// ctrl and Done decode from the registered state only.
module cu
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        Go,
  input  logic [2:0]  f,
  input  logic        Done_Calc,
  input  logic        Done_Div,
  output logic        Done,
  output logic [13:0] ctrl
);

  state_t     state;
  state_t     next;
  logic [2:0] f_r;

  // State register and function-code capture on IDLE->S1
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      f_r   <= 3'b000;
    end else begin
      state <= next;
      if (state == IDLE && Go)
        f_r <= f;
    end
  end

  // Next-state selection
  always_comb begin
    next = IDLE;
    case (state)
      IDLE: next = Go ? S1 : IDLE;
      S1:   next = S2;
      S2: begin
        if (f_r[2]) next = DISP;
        else begin
          case (f_r[1:0])
            2'd0:    next = S3_0;
            2'd1:    next = S3_1;
            2'd2:    next = S3_2;
            default: next = S3_3;
          endcase
        end
      end
      S3_0: next = S6_0;
      S3_1: next = S6_1;
      S3_2: next = S6_2;
      S3_3: next = S6_3;
      S6_0, S6_1, S6_2, S6_3:
        next = Done_Calc ? S9_0 : state;
      DISP: begin
        case (f_r[1:0])
          2'd0:    next = S5;
          2'd1:    next = S4_0;
          2'd2:    next = S9_1;
          default: next = S9_2;
        endcase
      end
      S5:   next = Done_Div ? S7 : S5;
      S7:   next = S9_0;
      S4_0: next = S4_1;
      S4_1: next = Done_Calc ? S8 : S4_1;
      S8:   next = S9_0;
      S9_0, S9_1, S9_2: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    ctrl = C_ZERO;
    Done = 1'b0;
    case (state)
      S1:   ctrl = C_S1;
      S2:   ctrl = C_S2;
      S3_0: ctrl = alu_word(C_S3, 2'd0);
      S3_1: ctrl = alu_word(C_S3, 2'd1);
      S3_2: ctrl = alu_word(C_S3, 2'd2);
      S3_3: ctrl = alu_word(C_S3, 2'd3);
      S6_0: ctrl = alu_word(C_S6, 2'd0);
      S6_1: ctrl = alu_word(C_S6, 2'd1);
      S6_2: ctrl = alu_word(C_S6, 2'd2);
      S6_3: ctrl = alu_word(C_S6, 2'd3);
      S4_0: ctrl = C_S4_0;
      S4_1: ctrl = C_S4_1;
      S8:   ctrl = C_S8;
      S5:   ctrl = C_S5;
      S7:   ctrl = C_S7;
      S9_0: begin ctrl = C_S9_0; Done = 1'b1; end
      S9_1: begin ctrl = C_S9_1; Done = 1'b1; end
      S9_2: begin ctrl = C_S9_2; Done = 1'b1; end
      default: ctrl = C_ZERO;
    endcase
  end

endmodule

// File: tb/tb_cu.sv
// Self-checking bench for the cu control unit.
// Expected {Done,ctrl} words are queued per cycle and popped after each edge.
module tb_cu;

  logic        clk;
  logic        rst;
  logic        Go;
  logic [2:0]  f;
  logic        Done_Calc;
  logic        Done_Div;
  logic        Done;
  logic [13:0] ctrl;

  int checks;
  int errors;
  logic [14:0] exp_q[$];

  cu dut (
    .clk(clk),
    .rst(rst),
    .Go(Go),
    .f(f),
    .Done_Calc(Done_Calc),
    .Done_Div(Done_Div),
    .Done(Done),
    .ctrl(ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [14:0] got,
    input logic [14:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got done=%0b ctrl=0x%04h, want done=%0b ctrl=0x%04h",
               tag, got[14], got[13:0], exp[14], exp[13:0]);
    end
  endtask

  task automatic step(
    input string       tag,
    input logic [13:0] c,
    input logic        d
  );
    logic [14:0] e;
    exp_q.push_back({d, c});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {Done, ctrl}, e);
    end
  endtask

  // One complete run from IDLE; ends observing IDLE.
  // f is scrambled after capture to show it is ignored.
  task automatic op(input logic [2:0] fv, input bit keep_go);
    logic [13:0] n8;
    f = fv;
    Go = 1'b1;
    Done_Calc = 1'b1;
    Done_Div = 1'b1;
    step("s1", 14'h3800, 1'b0);
    if (!keep_go) Go = 1'b0;
    f = ~fv;
    step("s2", 14'h2000, 1'b0);
    n8 = {4'b0, fv[1:0], 8'h00};
    if (!fv[2]) begin
      step("s3", 14'h0400 | n8, 1'b0);
      step("s6", 14'h0414 | n8, 1'b0);
      step("s9_0", 14'h0001, 1'b1);
    end else begin
      step("disp", 14'h0000, 1'b0);
      case (fv[1:0])
        2'd0: begin
          step("s5", 14'h0080, 1'b0);
          step("s7", 14'h00BC, 1'b0);
          step("s9_0", 14'h0001, 1'b1);
        end
        2'd1: begin
          step("s4_0", 14'h0060, 1'b0);
          step("s4_1", 14'h006C, 1'b0);
          step("s8", 14'h006C, 1'b0);
          step("s9_0", 14'h0001, 1'b1);
        end
        2'd2: step("s9_1", 14'h0002, 1'b1);
        default: step("s9_2", 14'h0003, 1'b1);
      endcase
    end
    step("idle", 14'h0000, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    Go = 1'b1;
    f = 3'b010;
    Done_Calc = 1'b1;
    Done_Div = 1'b0;

    step("rst0", 14'h0000, 1'b0);
    step("rst1", 14'h0000, 1'b0);
    rst = 1'b1;

    step("add_s1", 14'h3800, 1'b0);
    Go = 1'b0;
    step("add_s2", 14'h2000, 1'b0);
    step("add_s3_2", 14'h0600, 1'b0);
    step("add_s6_2", 14'h0614, 1'b0);
    step("add_s9_0", 14'h0001, 1'b1);
    step("add_idle", 14'h0000, 1'b0);
    step("idle_hold", 14'h0000, 1'b0);

    f = 3'b100;
    Go = 1'b1;
    Done_Div = 1'b0;
    step("div_s1", 14'h3800, 1'b0);
    Go = 1'b0;
    step("div_s2", 14'h2000, 1'b0);
    step("div_disp", 14'h0000, 1'b0);
    step("div_s5a", 14'h0080, 1'b0);
    step("div_s5b", 14'h0080, 1'b0);
    step("div_s5c", 14'h0080, 1'b0);
    Done_Div = 1'b1;
    step("div_s7", 14'h00BC, 1'b0);
    step("div_s9_0", 14'h0001, 1'b1);
    step("div_idle", 14'h0000, 1'b0);

    f = 3'b101;
    Go = 1'b1;
    Done_Calc = 1'b0;
    step("mul_s1", 14'h3800, 1'b0);
    Go = 1'b0;
    step("mul_s2", 14'h2000, 1'b0);
    step("mul_disp", 14'h0000, 1'b0);
    step("mul_s4_0", 14'h0060, 1'b0);
    step("mul_s4_1", 14'h006C, 1'b0);
    step("mul_s4_1h", 14'h006C, 1'b0);
    Done_Calc = 1'b1;
    step("mul_s8", 14'h006C, 1'b0);
    step("mul_s9_0", 14'h0001, 1'b1);
    step("mul_idle", 14'h0000, 1'b0);

    op(3'b110, 1'b0);
    op(3'b111, 1'b0);

    for (int i = 0; i < 8; i++)
      op(i[2:0], 1'b1);

    f = 3'b000;
    Go = 1'b1;
    Done_Calc = 1'b0;
    step("r_s1", 14'h3800, 1'b0);
    step("r_s2", 14'h2000, 1'b0);
    step("r_s3_0", 14'h0400, 1'b0);
    step("r_s6_0", 14'h0414, 1'b0);
    step("r_s6_0h", 14'h0414, 1'b0);
    rst = 1'b0;
    step("r_idle", 14'h0000, 1'b0);
    Go = 1'b0;
    rst = 1'b1;
    step("r_stay", 14'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
